// File: rtl/io_stim_seq.sv
// io_stim_seq: stimulus sequencer for the comp bring-up harness.
// It generates the DUT reset pulse and plays a loadable table of timed
// events onto CHANNELS output ports. A run ends after a programmable cycle
// budget. Playback can be one-shot or looping.
//
// Ports:
//   clk, reset       single clock, synchronous active-high reset
//   cfg_we/addr/...  table write port (chan, delay, value); accepted when not busy
//   n_events, loop   entry count and loop mode, latched at start
//   run_limit        run budget in cycles (0 = unlimited), latched at start
//   start            begin a run from IDLE or DONE
//   dut_reset        reset pulse to the DUT
//   chan_out         channel c occupies bits [c*WIDTH +: WIDTH]
//   event_strobe     high in the cycle a new event value first appears
//   event_idx        index of the last applied entry
//   busy, done       high in RST/WAIT/HOLD, and in DONE
module io_stim_seq #(
    parameter int WIDTH      = 32,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 16,
    parameter int DW         = 16,
    parameter int RST_CYCLES = 5,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [AW-1:0]             cfg_addr,
    input  logic [CW-1:0]             cfg_chan,
    input  logic [DW-1:0]             cfg_delay,
    input  logic [WIDTH-1:0]          cfg_value,
    input  logic [AW:0]               n_events,
    input  logic                      loop,
    input  logic [31:0]               run_limit,
    input  logic                      start,
    output logic                      dut_reset,
    output logic [CHANNELS*WIDTH-1:0] chan_out,
    output logic                      event_strobe,
    output logic [AW-1:0]             event_idx,
    output logic                      busy,
    output logic                      done
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_WAIT, S_HOLD, S_DONE} state_t;
    state_t state;

    // Event table. Reset does not clear it.
    logic [CW-1:0]    tbl_chan  [DEPTH];
    logic [DW-1:0]    tbl_delay [DEPTH];
    logic [WIDTH-1:0] tbl_value [DEPTH];

    logic [RCW-1:0] rst_cnt;
    logic [DW-1:0]  dcnt;
    logic [AW-1:0]  ptr;
    logic [31:0]    cycles;
    logic [31:0]    limit;
    logic [AW:0]    n_lat;
    logic           loop_lat;

    logic [AW:0]               n_clamped;
    logic [AW:0]               ptr_inc;
    logic                      last_entry;
    logic [AW-1:0]             nxt_ptr;
    logic                      limit_hit;
    logic [DW-1:0]             cur_delay;
    logic [CHANNELS*WIDTH-1:0] chan_applied;

    always_comb begin
        n_clamped  = (n_events > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : n_events;
        ptr_inc    = {1'b0, ptr} + (AW+1)'(1);
        last_entry = (ptr_inc >= n_lat);
        nxt_ptr    = last_entry ? '0 : ptr_inc[AW-1:0];
        // Decided one cycle ahead so that done shows in the cycle whose
        // count equals the limit.
        limit_hit  = (limit != '0) && ((cycles + 32'd1) == limit);
        // The last RST cycle acts as the first wait step of entry 0. This
        // lets a zero delay put event 0 in the first cycle with dut_reset low.
        cur_delay  = (state == S_RST) ? tbl_delay[ptr] : dcnt;
        chan_applied = chan_out;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (tbl_chan[ptr] == CW'(c)) begin
                chan_applied[c*WIDTH +: WIDTH] = tbl_value[ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            tbl_chan[cfg_addr]  <= cfg_chan;
            tbl_delay[cfg_addr] <= cfg_delay;
            tbl_value[cfg_addr] <= cfg_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            dut_reset    <= 1'b1;
            chan_out     <= '0;
            event_strobe <= 1'b0;
            event_idx    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rst_cnt      <= '0;
            dcnt         <= '0;
            ptr          <= '0;
            cycles       <= '0;
            limit        <= '0;
            n_lat        <= '0;
            loop_lat     <= 1'b0;
        end else begin
            event_strobe <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RST;
                        dut_reset <= 1'b1;
                        chan_out  <= '0;
                        event_idx <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        rst_cnt   <= '0;
                        dcnt      <= '0;
                        ptr       <= '0;
                        cycles    <= '0;
                        limit     <= run_limit;
                        n_lat     <= n_clamped;
                        loop_lat  <= loop;
                    end
                end
                default: begin
                    if (state == S_RST && rst_cnt != RST_LAST) begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end else begin
                        dut_reset <= 1'b0;
                        cycles    <= cycles + 32'd1;
                        if (limit_hit) begin
                            // Limit wins: a coinciding event is dropped.
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (state != S_HOLD) begin
                            if (state == S_RST && n_lat == '0) begin
                                if (limit == '0 && !loop_lat) begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    state <= S_HOLD;
                                end
                            end else if (cur_delay != '0) begin
                                dcnt  <= cur_delay - 1'b1;
                                state <= S_WAIT;
                            end else begin
                                chan_out     <= chan_applied;
                                event_strobe <= 1'b1;
                                event_idx    <= ptr;
                                if (last_entry && !loop_lat) begin
                                    if (limit == '0) begin
                                        state <= S_DONE;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end else begin
                                        state <= S_HOLD;
                                    end
                                end else begin
                                    ptr   <= nxt_ptr;
                                    dcnt  <= tbl_delay[nxt_ptr];
                                    state <= S_WAIT;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_stim_seq.sv
// tb_io_stim_seq: directed bench for io_stim_seq.
// The bench plans each run from its own copy of the table and queues the
// expected events. Strobes seen on the DUT pop the queue. A second instance
// with three channels exercises an entry whose channel is out of range.
module tb_io_stim_seq;
    localparam int W  = 8;
    localparam int RC = 5;
    localparam int L  = RC + 1;   // first cycle after start with dut_reset low

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic        cfg_we3 = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [1:0]  cfg_chan = '0;
    logic [15:0] cfg_delay = '0;
    logic [7:0]  cfg_value = '0;
    logic [2:0]  n_events = '0;
    logic        loop = 1'b0;
    logic [31:0] run_limit = '0;
    logic        start = 1'b0;
    logic        start3 = 1'b0;

    logic        dut_reset, event_strobe, busy, done;
    logic [15:0] chan_out;
    logic [1:0]  event_idx;
    logic        dut_reset3, event_strobe3, busy3, done3;
    logic [23:0] chan_out3;
    logic [1:0]  event_idx3;

    io_stim_seq #(.WIDTH(W), .CHANNELS(2), .DEPTH(4), .DW(16), .RST_CYCLES(RC)) u_dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_chan(cfg_chan[0]), .cfg_delay(cfg_delay), .cfg_value(cfg_value),
        .n_events(n_events), .loop(loop), .run_limit(run_limit), .start(start),
        .dut_reset(dut_reset), .chan_out(chan_out), .event_strobe(event_strobe),
        .event_idx(event_idx), .busy(busy), .done(done)
    );

    io_stim_seq #(.WIDTH(W), .CHANNELS(3), .DEPTH(4), .DW(16), .RST_CYCLES(RC)) u_dut3 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we3), .cfg_addr(cfg_addr),
        .cfg_chan(cfg_chan), .cfg_delay(cfg_delay), .cfg_value(cfg_value),
        .n_events(n_events), .loop(loop), .run_limit(run_limit), .start(start3),
        .dut_reset(dut_reset3), .chan_out(chan_out3), .event_strobe(event_strobe3),
        .event_idx(event_idx3), .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        int          idx;
        logic [23:0] ch;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;
    int  done_at;
    int  m_ch [4];
    int  m_delay [4];
    int  m_val [4];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_entry(bit sel3, int addr, int ch, int d, int v);
        cfg_addr  = 2'(addr);
        cfg_chan  = 2'(ch);
        cfg_delay = 16'(d);
        cfg_value = 8'(v);
        if (sel3) cfg_we3 = 1'b1; else cfg_we = 1'b1;
        m_ch[addr]    = ch;
        m_delay[addr] = d;
        m_val[addr]   = v;
        tick();
        cfg_we  = 1'b0;
        cfg_we3 = 1'b0;
    endtask

    // Expected event times, indices and channel images relative to the
    // start cycle, plus the cycle where done first rises (0 = never).
    task automatic plan(int n, bit lp, int lim, int nch);
        int          t, k, last_t, lim_t;
        logic [23:0] m;
        q.delete();
        m      = '0;
        last_t = L;
        lim_t  = (lim != 0) ? L + lim - 1 : 0;
        done_at = lim_t;
        if (n > 0) begin
            k = 0;
            t = L + m_delay[0];
            while ((lim_t == 0 || t < lim_t) && q.size() < 64) begin
                if (m_ch[k] < nch) m[m_ch[k]*8 +: 8] = 8'(m_val[k]);
                q.push_back('{t, k, m});
                last_t = t;
                if (k + 1 < n) k++;
                else if (lp) k = 0;
                else break;
                t = t + m_delay[k] + 1;
            end
        end
        if (lim == 0 && !lp) done_at = last_t;
    endtask

    // One run: start, then check every cycle up to ncyc. At cycle poke the
    // bench drives a write, a start and new n_events/loop while busy.
    task automatic play(bit sel3, int n, bit lp, int lim, int ncyc, int poke, bit full);
        logic [23:0] held;
        logic [23:0] obs_ch;
        logic        obs_dr, obs_busy, obs_done, obs_stb;
        logic [1:0]  obs_idx;
        ev_t         e;
        held = '0;
        plan(n, lp, lim, sel3 ? 3 : 2);
        n_events  = 3'(n);
        loop      = lp;
        run_limit = 32'(lim);
        if (sel3) start3 = 1'b1; else start = 1'b1;
        tick();
        start  = 1'b0;
        start3 = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            obs_ch   = sel3 ? chan_out3 : {8'h00, chan_out};
            obs_dr   = sel3 ? dut_reset3 : dut_reset;
            obs_busy = sel3 ? busy3 : busy;
            obs_done = sel3 ? done3 : done;
            obs_stb  = sel3 ? event_strobe3 : event_strobe;
            obs_idx  = sel3 ? event_idx3 : event_idx;
            chk("dut_reset", 32'(obs_dr), 32'(k <= RC));
            chk("busy", 32'(obs_busy), 32'(done_at == 0 || k < done_at));
            chk("done", 32'(obs_done), 32'(done_at != 0 && k >= done_at));
            if (obs_stb) begin
                if (q.size() == 0) begin
                    chk("extra_strobe", 32'(k), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("ev_time", 32'(k), 32'(e.t));
                    chk("ev_idx", 32'(obs_idx), 32'(e.idx));
                    chk("ev_chan", 32'(obs_ch), 32'(e.ch));
                    held = e.ch;
                end
            end else begin
                chk("chan_hold", 32'(obs_ch), 32'(held));
            end
            if (k == poke) begin
                cfg_we    = 1'b1;
                cfg_addr  = 2'd0;
                cfg_chan  = 2'd1;
                cfg_delay = 16'd0;
                cfg_value = 8'hFF;
                start     = 1'b1;
                n_events  = 3'd1;
                loop      = 1'b1;
            end else begin
                cfg_we   = 1'b0;
                start    = 1'b0;
                n_events = 3'(n);
                loop     = lp;
            end
            tick();
        end
        cfg_we = 1'b0;
        start  = 1'b0;
        if (full) chk("events_left", 32'(q.size()), 32'(0));
        q.delete();
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_dut_reset", 32'(dut_reset), 32'(1));
        chk("rst_chan_out", 32'(chan_out), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_strobe", 32'(event_strobe), 32'(0));
        chk("rst_idx", 32'(event_idx), 32'(0));
        reset = 1'b0;

        // One-shot playback: events at L+3, L+6, L+7, done at L+19
        write_entry(0, 0, 0, 3, 8'h0E);
        write_entry(0, 1, 0, 2, 8'h1B);
        write_entry(0, 2, 1, 0, 8'h01);
        repeat (3) tick();
        play(0, 3, 0, 20, 30, 0, 1);

        // Looping playback: the limit coincides with an event that is dropped
        write_entry(0, 0, 0, 1, 8'hAA);
        write_entry(0, 1, 0, 1, 8'h55);
        play(0, 2, 1, 10, 20, 0, 1);

        // No events, unlimited, one-shot: DONE straight after RST
        play(0, 0, 0, 0, 10, 0, 1);

        // Mid-run reset, then replays with busy-time writes and starts
        write_entry(0, 0, 0, 3, 8'h0E);
        write_entry(0, 1, 0, 2, 8'h1B);
        write_entry(0, 2, 1, 0, 8'h01);
        play(0, 3, 0, 20, 10, 0, 0);
        reset = 1'b1;
        tick();
        chk("mid_rst_dut_reset", 32'(dut_reset), 32'(1));
        chk("mid_rst_chan_out", 32'(chan_out), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        tick();
        reset = 1'b0;
        tick();
        play(0, 3, 0, 20, 30, 8, 1);
        play(0, 3, 0, 20, 30, 0, 1);

        // Out-of-range channel on the three-channel instance: strobe only
        write_entry(1, 0, 0, 1, 8'h11);
        write_entry(1, 1, 3, 1, 8'h22);
        write_entry(1, 2, 2, 0, 8'h33);
        play(1, 3, 0, 12, 20, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_stim_seq.md
# io_stim_seq

Parametrised, synthesizable stimulus sequencer for the `comp` bring-up harness. It generates the DUT reset pulse and plays a loadable table of timed events onto `CHANNELS` output ports, each `WIDTH` bits wide; in the standard harness these are the button and switch ports. It ends the run after a programmable cycle budget. One-shot and looping playback are supported, so scripted input sequences can run on the board as well as in simulation.

## Interface
- `WIDTH`, 32, bits per channel
- `CHANNELS`, 2, number of output channels
- `DEPTH`, 16, event table entries (power of 2)
- `DW`, 16, delay field width
- `RST_CYCLES`, 5, DUT reset pulse length in cycles (≥1)
- AW = $clog2(DEPTH), CW = max(1,$clog2(CHANNELS)) (derived)

Ports:
- `clk` in 1: the single clock
- `reset` in 1: synchronous, active-high
- `cfg_we` in 1: write table entry `cfg_addr`
- `cfg_addr` in AW: table entry index
- `cfg_chan` in CW: target channel
- `cfg_delay` in DW: entry delay
- `cfg_value` in WIDTH: entry value
- `n_events` in AW+1: number of valid entries, sampled at start
- `loop` in 1: loop mode, sampled at start
- `run_limit` in 32: run length in cycles; 0 = unlimited
- `start` in 1: begin run
- `dut_reset` out 1: reset to DUT
- `chan_out` out CHANNELS*WIDTH: channel c occupies bits [c*WIDTH +: WIDTH]
- `event_strobe` out 1: high in the cycle a new event value first appears
- `event_idx` out AW: index of the last applied entry
- `busy` out 1: high in RST, WAIT and HOLD
- `done` out 1: high in DONE

## Operation
- States: IDLE, RST, WAIT, HOLD, DONE.
- Reset values: state IDLE, `dut_reset`=1, `chan_out`=0, `event_strobe`=0, `event_idx`=0, `busy`=0, `done`=0.
- Table RAM is not cleared by reset; its contents survive reset.
- IDLE:
  - `cfg_we` writes the table.
  - `start` → RST. `chan_out` clears to 0, `dut_reset`=1, cycle counter and entry pointer clear.
- RST: hold `dut_reset`=1 for RST_CYCLES cycles.
  - Then → WAIT on entry 0.
  - If `n_events`=0, → HOLD instead.
- WAIT: the delay counter is loaded with `delay[k]` and decrements.
  - At zero, `value[k]` is written to channel `chan[k]`. Other channels are unchanged. `event_strobe` pulses and `event_idx`=k.
  - Next, k+1 < n_events → WAIT(k+1).
  - Last entry with `loop`=1 → WAIT(0).
  - Last entry with `loop`=0 → HOLD.
- HOLD: outputs are frozen and wait for the run limit. If `run_limit`=0 and the mode is one-shot → DONE immediately.
- Run limit:
  - The cycle counter counts cycles with `dut_reset`=0 in WAIT/HOLD.
  - When count reaches `run_limit`≠0 → DONE from either state.
  - Limit wins over a coinciding event: that event is not applied and gives no strobe.
- DONE: `chan_out` holds and `dut_reset`=0. `start` restarts as from IDLE.
- `cfg_we`, `start`, `loop` and `n_events` changes while `busy` are ignored.
- `chan[k]` ≥ CHANNELS: the entry consumes its delay and strobes, but drives nothing.
- `n_events` > DEPTH is clamped to DEPTH.
- `loop`=1 with `run_limit`=0 runs until `reset`.
- `reset` mid-run → IDLE next cycle with reset values. `dut_reset` reasserts immediately.

## Timing
- `start` sampled high in cycle t:
  - `dut_reset`=1 in cycles t+1 … t+RST_CYCLES.
  - First low cycle is L = t+RST_CYCLES+1.
- Event 0 is visible (value + strobe) in cycle L+delay[0].
- Event k is visible delay[k]+1 cycles after event k−1.
- Delay 0 on k>0 gives back-to-back events.
- Delay saturates at 2^DW−1; no wrap.
- `done` first high in cycle L+run_limit−1, when the count reaches run_limit (cycle L has count 1).
- A write in cycle t is readable by a start in cycle t+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Common parameters: WIDTH=8, CHANNELS=2, DEPTH=4, RST_CYCLES=5.

- **Reset values:** hold `reset` → `dut_reset`=1, `chan_out`=0, `busy`=0, `done`=0. Release reset, pulse `start` at t=10 → `dut_reset` high cycles 11–15, low from 16.
- **One-shot:**
  - Table {(0,3,0x0E),(0,2,0x1B),(1,0,0x01)}, `n_events`=3, `run_limit`=20.
  - Expected: ch0=0x0E at L+3, ch0=0x1B at L+6, ch1=0x01 at L+7. Three strobes, `event_idx` 0,1,2.
  - HOLD follows, then `done` at L+19.
- **Loop:**
  - Table {(0,1,0xAA),(0,1,0x55)}, `loop`=1, `run_limit`=10.
  - Expected: ch0 alternates AA/55 every 2 cycles from L+1.
  - Limit coincides with an event → that event is suppressed and `done` asserts.
- **Edge configurations:**
  - `n_events`=0, `run_limit`=0, one-shot → DONE directly after RST with no strobes.
  - `chan`=3 entry → strobe only, `chan_out` unchanged.
- **Mid-run reset and restart:**
  - `reset` during WAIT → IDLE, `dut_reset`=1, `chan_out`=0, table contents intact.
  - `start` from DONE → `chan_out` clears and the sequence replays identically.
- **Ignored inputs while busy:** `cfg_we` and `start` while busy → table and timing unchanged. Confirm by readback via a replay.
